// File: rtl/arb_mux_pkg.sv
// Shared constants and helpers for the N-way arbitrating multiplexer.
package arb_mux_pkg;

   // Arbitration modes, kept next to the other bus constants
   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

   // Width of a channel index; never narrower than one bit
   function automatic int srcWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/arb_mux_rr_arbiter.sv
// Combinational grant logic: fixed priority (lowest index) or round-robin
// starting just after the last granted channel.
module rr_arbiter
   import arb_mux_pkg::*;
#(
   parameter int  N     = 2,
   parameter int  ARB   = ARB_RR,
   localparam int SRC_W = srcWidth(N)
) (
   input  logic [N-1:0]     req,
   input  logic [SRC_W-1:0] ptr,
   input  logic             en,
   output logic [N-1:0]     gnt,
   output logic [SRC_W-1:0] gntIdx
);

   logic found;
   int   startIdx;
   int   cand;

   // Walk the channels in priority order and pick the first requester;
   // the one-hot grant is gated by en, the encoded index is not
   always_comb begin
      gnt      = '0;
      gntIdx   = '0;
      found    = 1'b0;
      cand     = 0;
      startIdx = (ARB == ARB_RR) ? int'(ptr) + 1 : 0;
      for (int k = 0; k < N; k++) begin
         cand = startIdx + k;
         if (cand >= N) begin
            cand = cand - N;
         end
         if (!found && req[cand]) begin
            found       = 1'b1;
            gnt[cand]   = en;
            gntIdx      = cand[SRC_W-1:0];
         end
      end
   end

endmodule

// File: rtl/arb_mux.sv
// Registered N-way arbitrating multiplexer: merges N valid/ready channels
// into one registered output channel.
module arb_mux
   import arb_mux_pkg::*;
#(
   parameter int  WIDTH = 32,
   parameter int  N     = 2,
   parameter int  ARB   = ARB_RR,
   localparam int SRC_W = srcWidth(N)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N-1:0]       in_valid,
   input  logic [N*WIDTH-1:0] in_data,
   output logic [N-1:0]       in_ready,
   output logic               out_valid,
   output logic [WIDTH-1:0]   out_data,
   output logic [SRC_W-1:0]   out_src,
   input  logic               out_ready
);

   logic [N-1:0]     reqClean;
   logic             loadEn;
   logic             arbEn;
   logic [N-1:0]     gnt;
   logic [SRC_W-1:0] gntIdx;
   logic [WIDTH-1:0] selData;

   logic             outValid_q, outValid_d;
   logic [WIDTH-1:0] outData_q,  outData_d;
   logic [SRC_W-1:0] outSrc_q,   outSrc_d;
   logic [SRC_W-1:0] ptr_q,      ptr_d;

   // Only a solid 1 counts as a request; X/Z are treated as idle
   always_comb begin
      reqClean = '0;
      for (int i = 0; i < N; i++) begin
         reqClean[i] = (in_valid[i] === 1'b1);
      end
   end

   // The output register can take a new item when empty or being drained;
   // grants are suppressed entirely while reset is held
   always_comb begin
      loadEn = !outValid_q || out_ready;
      arbEn  = loadEn && !rst;
   end

   rr_arbiter #(
      .N   (N),
      .ARB (ARB)
   ) uArbiter (
      .req    (reqClean),
      .ptr    (ptr_q),
      .en     (arbEn),
      .gnt    (gnt),
      .gntIdx (gntIdx)
   );

   // AND-OR payload select so non-granted data can never leak through
   always_comb begin
      selData = '0;
      for (int i = 0; i < N; i++) begin
         selData = selData | (in_data[i*WIDTH +: WIDTH] & {WIDTH{gnt[i]}});
      end
   end

   // Next state: load the winner, go empty when drained with no requester,
   // otherwise hold the current item untouched
   always_comb begin
      outValid_d = outValid_q;
      outData_d  = outData_q;
      outSrc_d   = outSrc_q;
      ptr_d      = ptr_q;
      if (loadEn) begin
         if (|reqClean) begin
            outValid_d = 1'b1;
            outData_d  = selData;
            outSrc_d   = gntIdx;
            if (ARB == ARB_RR) begin
               ptr_d = gntIdx;
            end
         end else begin
            outValid_d = 1'b0;
         end
      end
   end

   // State registers; reset leaves channel 0 with first round-robin priority
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         outValid_q <= 1'b0;
         outData_q  <= '0;
         outSrc_q   <= '0;
         ptr_q      <= SRC_W'(N - 1);
      end else begin
         outValid_q <= outValid_d;
         outData_q  <= outData_d;
         outSrc_q   <= outSrc_d;
         ptr_q      <= ptr_d;
      end
   end

   assign in_ready  = gnt;
   assign out_valid = outValid_q;
   assign out_data  = outData_q;
   assign out_src   = outSrc_q;

endmodule

// File: tb/tb_arb_mux.sv
// Self-checking bench for arb_mux: a 3-channel round-robin instance and a
// 4-channel fixed-priority instance driven side by side against a model.
module tb_arb_mux;
   import arb_mux_pkg::*;

   logic         clk;
   logic         rst;

   logic [2:0]   inValidA;
   logic [95:0]  inDataA;
   logic [2:0]   inReadyA;
   logic         outValidA;
   logic [31:0]  outDataA;
   logic [1:0]   outSrcA;
   logic         outReadyA;

   logic [3:0]   inValidB;
   logic [127:0] inDataB;
   logic [3:0]   inReadyB;
   logic         outValidB;
   logic [31:0]  outDataB;
   logic [1:0]   outSrcB;
   logic         outReadyB;

   arb_mux #(.WIDTH(32), .N(3), .ARB(ARB_RR)) dutA (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (inValidA),
      .in_data   (inDataA),
      .in_ready  (inReadyA),
      .out_valid (outValidA),
      .out_data  (outDataA),
      .out_src   (outSrcA),
      .out_ready (outReadyA)
   );

   arb_mux #(.WIDTH(32), .N(4), .ARB(ARB_FIXED)) dutB (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (inValidB),
      .in_data   (inDataB),
      .in_ready  (inReadyB),
      .out_valid (outValidB),
      .out_data  (outDataB),
      .out_src   (outSrcB),
      .out_ready (outReadyB)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checkCount = 0;
   int passCount  = 0;
   int failCount  = 0;

   int          nCh[2]     = '{3, 4};
   int          arbMode[2] = '{1, 0};
   bit          mValid[2];
   logic [31:0] mData[2];
   int          mSrc[2];
   int          mLast[2];
   int          lastAccept[2];

   bit          pend[2][4];
   logic [31:0] pdat[2][4];

   function automatic logic [3:0] getValid(int d);
      if (d == 0) return {1'b0, inValidA};
      return inValidB;
   endfunction

   function automatic logic [31:0] getData(int d, int i);
      if (d == 0) return inDataA[i*32 +: 32];
      return inDataB[i*32 +: 32];
   endfunction

   function automatic bit getOutReady(int d);
      if (d == 0) return outReadyA;
      return outReadyB;
   endfunction

   // Winner from the rules: lowest index, or first after last grant wrapping
   function automatic int pickWinner(int d);
      logic [3:0] v;
      int c;
      v = getValid(d);
      if (arbMode[d] == 0) begin
         for (int i = 0; i < nCh[d]; i++) begin
            if (v[i] === 1'b1) return i;
         end
      end else begin
         for (int step = 1; step <= nCh[d]; step++) begin
            c = (mLast[d] + step) % nCh[d];
            if (v[c] === 1'b1) return c;
         end
      end
      return -1;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      for (int d = 0; d < 2; d++) begin
         mValid[d] = 1'b0;
         mData[d]  = '0;
         mSrc[d]   = 0;
         mLast[d]  = nCh[d] - 1;
      end
   endtask

   task automatic checkState(input string tag);
      checkOutput({tag, "/validA"}, {31'b0, outValidA}, {31'b0, mValid[0]});
      checkOutput({tag, "/dataA"}, outDataA, mData[0]);
      checkOutput({tag, "/srcA"}, {30'b0, outSrcA}, 32'(mSrc[0]));
      checkOutput({tag, "/validB"}, {31'b0, outValidB}, {31'b0, mValid[1]});
      checkOutput({tag, "/dataB"}, outDataB, mData[1]);
      checkOutput({tag, "/srcB"}, {30'b0, outSrcB}, 32'(mSrc[1]));
   endtask

   // One clock cycle: check ready before the edge, advance model, check outputs
   task automatic applyStimulus();
      int         w[2];
      bit         le[2];
      logic [3:0] expRdy[2];
      #1;
      for (int d = 0; d < 2; d++) begin
         le[d]     = !mValid[d] || getOutReady(d);
         w[d]      = pickWinner(d);
         expRdy[d] = (!rst && le[d] && w[d] >= 0) ? 4'(1 << w[d]) : 4'b0;
      end
      checkOutput("readyA", {29'b0, inReadyA}, {28'b0, expRdy[0]});
      checkOutput("readyB", {28'b0, inReadyB}, {28'b0, expRdy[1]});
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
         lastAccept[d] = -1;
         if (!rst && le[d]) begin
            if (w[d] >= 0) begin
               mValid[d]     = 1'b1;
               mData[d]      = getData(d, w[d]);
               mSrc[d]       = w[d];
               lastAccept[d] = w[d];
               if (arbMode[d] == 1) mLast[d] = w[d];
            end else begin
               mValid[d] = 1'b0;
            end
         end
      end
      #1;
      checkState("cycle");
   endtask

   task automatic applyReset();
      rst = 1'b1;
      #1;
      modelReset();
      checkState("reset");
      applyStimulus();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      inValidA  = '1;
      inValidB  = '1;
      inDataA   = {32'h2222_2222, 32'h5555_FFFF, 32'hAAAA_0000};
      inDataB   = {$urandom, $urandom, $urandom, $urandom};
      outReadyA = 1'b1;
      outReadyB = 1'b1;
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 4; i++) begin
            pend[d][i] = 1'b0;
            pdat[d][i] = '0;
         end
      end

      // Reset with every request high: everything idle, no ready
      applyReset();

      // Round-robin on A with all valid; fixed priority on B with ch1 and ch3
      inValidB = 4'b1010;
      inDataB  = {32'h3333_0003, 32'h0, 32'h1111_0001, 32'h0};
      for (int c = 0; c < 6; c++) applyStimulus();
      checkOutput("fixedHoldsCh1", {30'b0, outSrcB}, 32'd1);
      inValidB = 4'b1000;
      applyStimulus();
      checkOutput("fixedServesCh3", {30'b0, outSrcB}, 32'd3);
      applyStimulus();

      // Backpressure on B while ch0 waits
      inValidA = '0;
      inValidB = 4'b0100;
      inDataB  = {32'h0, 32'h1234_5678, 32'h0, 32'hCAFE_F00D};
      applyStimulus();
      inValidB  = 4'b0001;
      outReadyB = 1'b0;
      for (int c = 0; c < 5; c++) applyStimulus();
      checkOutput("bpHold", outDataB, 32'h1234_5678);
      outReadyB = 1'b1;
      applyStimulus();
      checkOutput("bpRelease", outDataB, 32'hCAFE_F00D);
      inValidB = '0;

      // Round-robin from reset pointer: lone ch2 first, then wrap order
      applyReset();
      inValidA = 3'b100;
      applyStimulus();
      checkOutput("rrLoneCh2", {30'b0, outSrcA}, 32'd2);
      inValidA = 3'b111;
      for (int c = 0; c < 3; c++) applyStimulus();

      // Asynchronous reset mid-cycle with an item held
      #2;
      rst = 1'b1;
      #1;
      modelReset();
      checkState("asyncRst");
      applyStimulus();
      @(negedge clk);
      rst = 1'b0;
      applyStimulus();
      checkOutput("postRstCh0", {30'b0, outSrcA}, 32'd0);

      // Randomized traffic with producers holding requests until accepted
      for (int c = 0; c < 300; c++) begin
         for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < nCh[d]; i++) begin
               if (!pend[d][i] && $urandom_range(0, 1) == 1) begin
                  pend[d][i] = 1'b1;
                  pdat[d][i] = $urandom;
               end
            end
         end
         for (int i = 0; i < 3; i++) begin
            inValidA[i]         = pend[0][i];
            inDataA[i*32 +: 32] = pdat[0][i];
         end
         for (int i = 0; i < 4; i++) begin
            inValidB[i]         = pend[1][i];
            inDataB[i*32 +: 32] = pdat[1][i];
         end
         outReadyA = ($urandom_range(0, 3) != 0);
         outReadyB = ($urandom_range(0, 3) != 0);
         applyStimulus();
         for (int d = 0; d < 2; d++) begin
            if (lastAccept[d] >= 0) pend[d][lastAccept[d]] = 1'b0;
         end
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/arb_mux.md
# arb_mux

Registered N-way arbitrating multiplexer, the parametrised successor to the two-input datapath select. It merges N valid/ready request channels of WIDTH bits into one output channel through a single output register, choosing among simultaneous requesters by fixed priority or round-robin. It sits in front of the CPU's shared memory/bus interface, merging instruction-fetch and data requests, and is reusable anywhere several producers share one consumer.

## Interface
- WIDTH, 32, payload width in bits per channel (≥1)
- N, 2, number of input channels (2..16)
- ARB, 1, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin
- SRC_W, $clog2(N) (minimum 1), width of source index; derived, not overridden
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset; asynchronous, active-high
- in_valid  input  N  per-channel request; bit i belongs to channel i
- in_data  input  N*WIDTH  channel i payload in bits [i*WIDTH +: WIDTH]
- in_ready  output  N  per-channel accept; at most one bit high per cycle
- out_valid  output  1  output register holds a valid item
- out_data  output  WIDTH  registered payload
- out_src  output  SRC_W  index of channel that supplied out_data
- out_ready  input  1  consumer accepts out_data this cycle

## Operation
- Handshake on every channel: a transfer occurs in a cycle where valid && ready at the rising edge.
- load_en = !out_valid || out_ready (output register empty or being drained this cycle).
- grant: one-hot over in_valid. ARB=0: lowest set index. ARB=1: first set index searching ptr+1, ptr+2, … wrapping modulo N.
- in_ready[i] = load_en && grant[i]; combinational from in_valid, out_valid, out_ready, ptr.
- On edge with load_en and any in_valid: out_valid←1, out_data←in_data of granted channel, out_src←granted index, ptr←granted index (ARB=1 only).
- On edge with load_en and no in_valid: out_valid←0; out_data/out_src hold.
- On edge with !load_en: all state holds; no in_ready asserted.
- in_valid bits not exactly 1 (X/Z) are treated as deasserted; in_data of non-granted channels never reaches the output.
- Once an item is loaded it stays stable on out_data/out_src until accepted; no re-arbitration while out_valid && !out_ready.
- Producers must hold in_valid/in_data stable until accepted; the block does not require this for correctness but verification checks it.

## Timing
- Reset (async assert, sync-safe deassert by system): out_valid=0, out_data=0, out_src=0, ptr=N-1 (channel 0 has first round-robin priority); in_ready=0 follows because grant is masked until load_en is evaluated with out_valid=0 — with rst high, in_ready is forced 0.
- Latency: input accepted at edge k appears on out_valid/out_data after edge k (one cycle).
- Throughput: one item per cycle sustained when out_ready held high.
- Simultaneous drain and load: out_valid && out_ready && any in_valid → new item loaded in same edge, out_valid stays 1.
- Round-robin wrap: after granting N-1, search restarts at 0.
- Single requester always granted within one cycle of load_en regardless of ptr.
- Reset mid-transfer: pending output item is discarded; no in_ready during rst.

## Structure
- Arbitration-mode constants (ARB_FIXED=0, ARB_RR=1) go in the shared CPU defines header, beside the other bus constants.
- One sub-module: rr_arbiter (parameters N, ARB; inputs req[N], ptr, en; output one-hot gnt[N] and encoded index), purely combinational. arb_mux holds the registers, the payload select, and the handshake logic.

## Test plan
- Reset: hold rst with all in_valid=1 → out_valid=0, out_data=0, out_src=0, in_ready=0.
- N=2, ARB=1, both valid every cycle, out_ready=1, data ch0=0xAAAA0000, ch1=0x5555FFFF → outputs alternate ch0,ch1,ch0… starting at ch0, one per cycle, out_src 0,1,0.
- N=4, ARB=0, channels 1 and 3 valid → only channel 1 granted until it drops; channel 3 then served next cycle.
- Backpressure: load 0x12345678 from ch2, out_ready=0 for 5 cycles while ch0 is valid → out_data stays 0x12345678, in_ready=0; on out_ready=1, ch0 loads the same edge.
- N=3, ARB=1, ptr=2, only ch2 valid → ch2 granted immediately; then all valid → ch0, ch1, ch2 order (wrap-around).
- Async reset asserted mid-cycle while out_valid=1 → out_valid drops immediately without a clock edge; after release, channel 0 has first priority.
